// File: rtl/pitch_pkg.sv
// pitch_pkg: shared encodings for the pitch-correction pipeline.
// Holds the one-hot FSM state type, complex word field numbers and the abs saturation helper.
package pitch_pkg;
  typedef enum logic [3:0] {
    S_IDLE     = 4'b0001,
    S_WAIT_FFT = 4'b0010,
    S_FILL     = 4'b0100,
    S_DONE     = 4'b1000
  } state_t;
  // A complex word is {real, imag}; field f sits at [f*half +: half].
  localparam int RE_FIELD = 1;
  localparam int IM_FIELD = 0;
  // Largest positive value of a signed half_w-bit field: |most-negative| clamps here.
  function automatic logic [63:0] mag_sat(input int half_w);
    return (64'd1 << (half_w - 1)) - 64'd1;
  endfunction
endpackage

// File: rtl/mag_estimator.sv
// mag_estimator: alpha-max-beta-min magnitude, max(|re|,|im|) + min(|re|,|im|)/2.
// Ports: i_data complex word {re, im}, o_mag unsigned estimate (MAG_W bits, cannot overflow).
module mag_estimator
  import pitch_pkg::*;
#(
  parameter int DATA_W = 36,
  parameter int MAG_W  = DATA_W / 2 + 1
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [MAG_W-1:0]  o_mag
);
  localparam int H = DATA_W / 2;
  localparam logic [H-1:0] SAT      = H'(mag_sat(H));
  localparam logic [H-1:0] MOST_NEG = {1'b1, {(H-1){1'b0}}};
  function automatic logic [H-1:0] abs_sat(input logic [H-1:0] x);
    return x[H-1] ? ((x == MOST_NEG) ? SAT : H'(-x)) : x;
  endfunction
  logic [H-1:0] w_a, w_b, w_max, w_min;
  assign w_a   = abs_sat(i_data[RE_FIELD*H +: H]);
  assign w_b   = abs_sat(i_data[IM_FIELD*H +: H]);
  assign w_max = (w_a > w_b) ? w_a : w_b;
  assign w_min = (w_a > w_b) ? w_b : w_a;
  assign o_mag = MAG_W'(w_max) + MAG_W'(w_min >> 1);
endmodule

// File: rtl/spectral_frame_sequencer.sv
// spectral_frame_sequencer: fetches one FFT frame into a frame RAM, tracks the magnitude peak, serves the frame.
// Ports: start/done frame control; fft_* read handshake toward the FFT; result_* read port for downstream;
// peak_index/peak_mag/peak_valid spectral peak of the current frame.
// Build option DC_EXCLUDE_EN: bin 0 is stored but left out of the peak search.
module spectral_frame_sequencer
  import pitch_pkg::*;
#(
  parameter int N_BINS = 512,
  parameter int DATA_W = 36,
  parameter int ADDR_W = $clog2(N_BINS),
  parameter int MAG_W  = DATA_W / 2 + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  input  logic              fft_done,
  output logic [ADDR_W-1:0] fft_address,
  output logic              fft_read_enable,
  input  logic              fft_read_valid,
  input  logic [DATA_W-1:0] fft_data,
  input  logic [ADDR_W-1:0] result_address,
  input  logic              result_read_enable,
  output logic [DATA_W-1:0] result_data,
  output logic              result_read_valid,
  output logic [ADDR_W-1:0] peak_index,
  output logic [MAG_W-1:0]  peak_mag,
  output logic              peak_valid
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_BINS - 1);
`ifdef DC_EXCLUDE_EN
  localparam logic [ADDR_W-1:0] PEAK_INIT = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] PEAK_INIT = '0;
`endif
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_issue, r_wr, r_peak_idx;
  logic              r_issue_done, r_rvalid, r_peak_valid;
  logic [MAG_W-1:0]  r_peak_mag, w_mag;
  logic [DATA_W-1:0] r_ram [N_BINS];
  logic [DATA_W-1:0] r_rdata;
  logic              w_wr, w_last, w_search, w_better, w_rd;
  mag_estimator #(.DATA_W(DATA_W), .MAG_W(MAG_W)) u_mag (.i_data(fft_data), .o_mag(w_mag));
`ifdef DC_EXCLUDE_EN
  assign w_search = r_wr != '0;
`else
  assign w_search = 1'b1;
`endif
  assign w_wr     = r_state == S_FILL && fft_read_valid;
  assign w_last   = w_wr && r_wr == LAST;
  // Strict compare keeps the lowest index on ties.
  assign w_better = w_wr && w_search && w_mag > r_peak_mag;
  assign w_rd     = r_state == S_IDLE && result_read_enable;
  always_comb begin
    w_next          = (r_state == S_IDLE && start)        ? S_WAIT_FFT :
                      (r_state == S_WAIT_FFT && fft_done) ? S_FILL :
                      w_last                              ? S_DONE :
                      (r_state == S_DONE)                 ? S_IDLE : r_state;
    done            = r_state == S_IDLE;
    fft_read_enable = r_state == S_FILL && !r_issue_done;
    fft_address     = r_issue;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_issue      <= '0;
      r_issue_done <= 1'b0;
      r_wr         <= '0;
      r_rvalid     <= 1'b0;
      r_peak_valid <= 1'b0;
      r_peak_idx   <= '0;
      r_peak_mag   <= '0;
    end else begin
      r_state      <= w_next;
      r_rvalid     <= w_rd;
      r_peak_valid <= w_last || (r_peak_valid && w_next != S_WAIT_FFT);
      if (r_state == S_WAIT_FFT) begin
        r_issue      <= '0;
        r_issue_done <= 1'b0;
        r_wr         <= '0;
        r_peak_idx   <= PEAK_INIT;
        r_peak_mag   <= '0;
      end
      // The issue counter wraps to 0 after the last address, leaving fft_address at 0 when idle.
      if (r_state == S_FILL && !r_issue_done) begin
        r_issue      <= r_issue + 1'b1;
        r_issue_done <= r_issue == LAST;
      end
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_better) begin
        r_peak_idx <= r_wr;
        r_peak_mag <= w_mag;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_ram[r_wr] <= fft_data;
    if (w_rd) r_rdata <= r_ram[result_address];
  end
  assign result_data       = r_rdata;
  assign result_read_valid = r_rvalid;
  assign peak_index        = r_peak_idx;
  assign peak_mag          = r_peak_mag;
  assign peak_valid        = r_peak_valid;
endmodule

// File: tb/tb_spectral_frame_sequencer.sv
// tb_spectral_frame_sequencer: directed self-checking bench for spectral_frame_sequencer (N_BINS=16, DATA_W=36).
module tb_spectral_frame_sequencer;
`ifdef DC_EXCLUDE_EN
  localparam int DC_EXCL = 1;
`else
  localparam int DC_EXCL = 0;
`endif
  logic        clk = 1'b0;
  logic        reset, start, fft_done, fft_read_valid, result_read_enable;
  logic        done, fft_read_enable, result_read_valid, peak_valid;
  logic [3:0]  fft_address, result_address, peak_index;
  logic [35:0] fft_data, result_data;
  logic [18:0] peak_mag;
  logic [35:0] frame [16];
  logic        lat_mode = 1'b0;
  logic        lv = 1'b0;
  logic [35:0] ld = '0;
  int          cyc = 0, wp = 0, rp = 0;
  logic [3:0]  req_a [256];
  int          req_t [256];
  int          errors = 0, checks = 0;

  spectral_frame_sequencer #(.N_BINS(16), .DATA_W(36)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .fft_done(fft_done),
    .fft_address(fft_address), .fft_read_enable(fft_read_enable), .fft_read_valid(fft_read_valid),
    .fft_data(fft_data), .result_address(result_address), .result_read_enable(result_read_enable),
    .result_data(result_data), .result_read_valid(result_read_valid), .peak_index(peak_index),
    .peak_mag(peak_mag), .peak_valid(peak_valid)
  );

  always #5 clk = ~clk;

  // FFT model: zero latency answers in the request cycle; latency mode answers >=3 cycles later with random gaps.
  assign fft_read_valid = lat_mode ? lv : fft_read_enable;
  assign fft_data       = lat_mode ? ld : frame[fft_address];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lat_mode && fft_read_enable) begin
      req_a[wp % 256] <= fft_address;
      req_t[wp % 256] <= cyc;
      wp <= wp + 1;
    end
    lv <= 1'b0;
    if (lat_mode && rp < wp && cyc - req_t[rp % 256] >= 2 && $urandom_range(0, 2) != 0) begin
      lv <= 1'b1;
      ld <= frame[req_a[rp % 256]];
      rp <= rp + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < 16; k++) frame[k] = {18'(k), 18'd0};
  endtask

  task automatic fill_zero();
    for (int k = 0; k < 16; k++) frame[k] = '0;
  endtask

  task automatic read_check(input int a, input logic [35:0] exp, input string nm);
    result_address = 4'(a);
    result_read_enable = 1'b1;
    tick();
    result_read_enable = 1'b0;
    checks++;
    if (result_read_valid !== 1'b1 || result_data !== exp) begin
      errors++;
      $display("FAIL %s: addr %0d got valid=%b data=%h, want valid=1 data=%h", nm, a, result_read_valid, result_data, exp);
    end
  endtask

  // Runs one frame from start to the first peak_valid cycle; rst_at>0 aborts with reset on that valid.
  task automatic run_frame(input string nm, input int wait_cycles, input bit mid_start, input int rst_at);
    int nval = 0;
    bit bad_rd = 0, bad_en = 0;
    logic [35:0] rd0;
    fft_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || peak_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s start: got done=%b peak_valid=%b, want 0 0", nm, done, peak_valid);
    end
    rd0 = result_data;
    result_read_enable = 1'b1;
    for (int c = 0; c < wait_cycles; c++) begin
      if (fft_read_enable !== 1'b0) bad_en = 1;
      tick();
    end
    fft_done = 1'b1;
    for (int c = 0; c < 400 && peak_valid !== 1'b1; c++) begin
      if (result_read_valid !== 1'b0) bad_rd = 1;
      if (fft_read_valid) nval++;
      start = mid_start && nval == 5;
      if (rst_at > 0 && nval == rst_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        result_read_enable = 1'b0;
        start = 1'b0;
        return;
      end
      tick();
    end
    start = 1'b0;
    result_read_enable = 1'b0;
    checks++;
    if (peak_valid !== 1'b1 || nval != 16) begin
      errors++;
      $display("FAIL %s completion: got peak_valid=%b after %0d valids, want 1 after 16", nm, peak_valid, nval);
    end
    checks++;
    if (bad_en || bad_rd || result_data !== rd0) begin
      errors++;
      $display("FAIL %s busy_ports: got early_enable=%b read_valid=%b data=%h, want 0 0 %h", nm, bad_en, bad_rd, result_data, rd0);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_state: got done=%b, want 0", nm, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || peak_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s back_idle: got done=%b peak_valid=%b, want 1 1", nm, done, peak_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({done, peak_valid, fft_read_enable, fft_address, result_read_valid, peak_index, peak_mag} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 19'd0}) begin
      errors++;
      $display("FAIL reset: got done=%b pv=%b en=%b addr=%0d rv=%b idx=%0d mag=%0d, want 1 0 0 0 0 0 0",
               done, peak_valid, fft_read_enable, fft_address, result_read_valid, peak_index, peak_mag);
    end
  endtask

  task automatic test_basic();
    fill_ramp();
    run_frame("basic", 3, 1'b0, 0);
    checks++;
    if (peak_index !== 4'd15 || peak_mag !== 19'd15) begin
      errors++;
      $display("FAIL basic peak: got idx=%0d mag=%0d, want 15 15", peak_index, peak_mag);
    end
    read_check(3, {18'd3, 18'd0}, "basic_read3");
    read_check(15, {18'd15, 18'd0}, "basic_read15");
  endtask

  task automatic test_tie();
    fill_zero();
    frame[5] = {18'h3FF9C, 18'd40};
    frame[9] = {18'h3FF9C, 18'd40};
    run_frame("tie", 0, 1'b0, 0);
    checks++;
    if (peak_index !== 4'd5 || peak_mag !== 19'd120) begin
      errors++;
      $display("FAIL tie peak: got idx=%0d mag=%0d, want 5 120", peak_index, peak_mag);
    end
    read_check(9, {18'h3FF9C, 18'd40}, "tie_read9");
  endtask

  task automatic test_saturation();
    fill_zero();
    frame[2] = {18'h20000, 18'd0};
    run_frame("sat", 0, 1'b0, 0);
    checks++;
    if (peak_index !== 4'd2 || peak_mag !== 19'd131071) begin
      errors++;
      $display("FAIL sat peak: got idx=%0d mag=%0d, want 2 131071", peak_index, peak_mag);
    end
  endtask

  task automatic test_latency_gaps();
    fill_ramp();
    lat_mode = 1'b1;
    run_frame("gaps", 2, 1'b1, 0);
    lat_mode = 1'b0;
    checks++;
    if (peak_index !== 4'd15 || peak_mag !== 19'd15) begin
      errors++;
      $display("FAIL gaps peak: got idx=%0d mag=%0d, want 15 15", peak_index, peak_mag);
    end
    for (int k = 0; k < 16; k++) read_check(k, {18'(k), 18'd0}, "gaps_ram");
  endtask

  task automatic test_dc();
    fill_zero();
    frame[0] = {18'd1000, 18'd0};
    frame[4] = {18'd10, 18'd0};
    run_frame("dc", 0, 1'b0, 0);
    checks++;
    if (peak_index !== (DC_EXCL != 0 ? 4'd4 : 4'd0) || peak_mag !== (DC_EXCL != 0 ? 19'd10 : 19'd1000)) begin
      errors++;
      $display("FAIL dc peak: got idx=%0d mag=%0d, want %0d %0d", peak_index, peak_mag,
               DC_EXCL != 0 ? 4 : 0, DC_EXCL != 0 ? 10 : 1000);
    end
    read_check(0, {18'd1000, 18'd0}, "dc_read0");
  endtask

  task automatic test_all_zero();
    fill_zero();
    run_frame("zero", 0, 1'b0, 0);
    checks++;
    if (peak_index !== (DC_EXCL != 0 ? 4'd1 : 4'd0) || peak_mag !== 19'd0) begin
      errors++;
      $display("FAIL zero peak: got idx=%0d mag=%0d, want %0d 0", peak_index, peak_mag, DC_EXCL != 0 ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid();
    fill_ramp();
    run_frame("midrst", 0, 1'b0, 8);
    checks++;
    if (done !== 1'b1 || peak_valid !== 1'b0 || fft_read_enable !== 1'b0 || fft_address !== 4'd0 || peak_index !== 4'd0) begin
      errors++;
      $display("FAIL midrst state: got done=%b pv=%b en=%b addr=%0d idx=%0d, want 1 0 0 0 0",
               done, peak_valid, fft_read_enable, fft_address, peak_index);
    end
    fill_zero();
    frame[5] = {18'h3FF9C, 18'd40};
    frame[9] = {18'h3FF9C, 18'd40};
    run_frame("after_rst", 1, 1'b0, 0);
    checks++;
    if (peak_index !== 4'd5 || peak_mag !== 19'd120) begin
      errors++;
      $display("FAIL after_rst peak: got idx=%0d mag=%0d, want 5 120", peak_index, peak_mag);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fft_done = 1'b0;
    result_read_enable = 1'b0;
    result_address = '0;
    fill_zero();
    test_reset();
    test_basic();
    test_tie();
    test_saturation();
    test_latency_gaps();
    test_dc();
    test_all_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
